dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (image buffer) among three requesters: processor core data port, image loader (UART/host write-in), and VGA display reader.
- Round-robin arbitration, display urgency override, and a bounded loader burst lock.
- Sits between the core's memory stage (driven by WE_MEM/SEL_DAT decode) and the BRAM.
- Produces the core stall signal when the core loses arbitration.

Parameters:
- ADDR_W, 16, memory word-address width.
- DATA_W, 32, memory data width.
- MAX_BURST, 8, maximum consecutive loader grants under lock (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core access request, held until granted
- core_we  in  1  core write enable
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core granted this cycle
- core_rvalid  out  1  core read data valid on rdata
- core_stall  out  1  core_req & ~core_gnt
- load_req  in  1  loader request
- load_lock  in  1  loader requests burst continuation
- load_addr  in  ADDR_W  loader address (always write)
- load_wdata  in  DATA_W  loader write data
- load_gnt  out  1  loader granted
- disp_req  in  1  display read request
- disp_urgent  in  1  display line FIFO near empty; overrides all
- disp_addr  in  ADDR_W  display address (always read)
- disp_gnt  out  1  display granted
- disp_rvalid  out  1  display read data valid on rdata
- rdata  out  DATA_W  shared read-return bus (= mem_rdata)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read issue

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Registered state:
  - last winner pointer lw in {CORE, LOAD, DISP}; reset DISP, so CORE has first priority.
  - burst counter bc (8 bit); reset 0.
  - burst-active flag ba; reset 0.
  - core_rvalid / disp_rvalid registers; reset 0.
- Grants are combinational from the current requests and registered state. Exactly one or zero gnt is high per cycle.
- Winner selection, in priority order:
  1. disp_urgent & disp_req -> DISP.
  2. ba & load_req & load_lock & bc < MAX_BURST -> LOAD.
  3. Round-robin among asserted reqs, starting after lw (order CORE -> LOAD -> DISP -> CORE).
- Memory drive:
  - mem_en = any gnt.
  - mem_addr/mem_wdata come from the winner.
  - mem_we = core_we for CORE, 1 for LOAD, 0 for DISP.
  - With no winner: mem_en=0, mem_we=0; addr/wdata don't-care (drive 0).
- Read return, latency 1 cycle:
  - core_rvalid <= core_gnt & ~core_we.
  - disp_rvalid <= disp_gnt.
  - rdata = mem_rdata passthrough.
  - Writes produce no rvalid.
- Register updates on each edge with a winner: lw <= winner.
- Burst tracking:
  - LOAD granted with load_lock=1: ba <= 1, bc <= bc+1 (bc=1 after the first locked grant).
  - LOAD granted with load_lock=0, any other winner, or no request: ba <= 0, bc <= 0.
  - bc reaching MAX_BURST blocks rule 2. The following cycle uses round-robin with lw=LOAD, so CORE/DISP are served before the loader again. ba/bc then clear, since the grant went elsewhere or lock ends.
  - If the loader is the only requester at the cap, it wins by round-robin; bc restarts at 1.
- Urgent display preempts a burst: burst ends, bc <= 0.
- Requester rules:
  - A request with its gnt low must keep its req/addr/data stable. The arbiter does not latch them.
  - Deasserting req before grant is allowed (withdrawal) and has no side effects.
- Reset mid-operation:
  - All registered outputs clear immediately; an in-flight read's rvalid is dropped.
  - Requesters reissue after reset.

Decomposition:
- Shared package (mem_pkg):
  - requester IDs REQ_CORE=0, REQ_LOAD=1, REQ_DISP=2, as 2-bit constants.
  - default ADDR_W and DATA_W constants.
- Sub-module rr_pick3: combinational 3-way round-robin selector.
  - Inputs: req[2:0], lw[1:0].
  - Outputs: one-hot gnt[2:0].
  - Reused by a future I/O bus arbiter.

Test Plan:
- Reset, then core_req=1, we=0, addr=0x0010 alone -> core_gnt=1, mem_en=1, mem_we=0, mem_addr=0x0010; next cycle core_rvalid=1 and rdata = mem model value.
- All three req held, no lock/urgent -> grant order CORE, LOAD, DISP, CORE... for 6 cycles. core_stall=1 exactly on the 4 non-core cycles.
- Loader lock burst with MAX_BURST=8 and core_req held -> load_gnt for 8 consecutive cycles, then core_gnt on the 9th, then load_gnt resumes with bc=1.
- Loader at burst beat 3, disp_urgent=1 with disp_req -> disp_gnt that cycle and bc=0. Next cycle the loader is served only via round-robin after DISP.
- Core write we=1, data 0xDEADBEEF to 0x0100, then a display read of 0x0100 -> mem_we=1 on the write cycle with no core_rvalid. disp_rvalid the cycle after the display grant, with rdata=0xDEADBEEF.
- Display read granted, reset asserted before the next edge -> disp_rvalid stays 0, lw=DISP. Post-reset simultaneous core+disp requests -> core wins first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter and related bus arbiters.
// Latency: none (constants only).
// Backpressure: not applicable.
package mem_pkg;

    // Requester identifiers, also used as bit positions in request/grant vectors
    localparam logic [1:0] REQ_CORE = 2'd0;
    localparam logic [1:0] REQ_LOAD = 2'd1;
    localparam logic [1:0] REQ_DISP = 2'd2;

    // Default memory geometry
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin selector: picks the first asserted request after lw.
// Latency: purely combinational.
// Backpressure: none; losers simply see their grant bit low.
module rr_pick3
    import mem_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] lw,
    output logic [2:0] gnt
);

    // Search order rotates so the previous winner is considered last
    always_comb begin
        gnt = 3'b000;
        case (lw)
            REQ_CORE: begin
                if      (req[REQ_LOAD]) gnt[REQ_LOAD] = 1'b1;
                else if (req[REQ_DISP]) gnt[REQ_DISP] = 1'b1;
                else if (req[REQ_CORE]) gnt[REQ_CORE] = 1'b1;
            end
            REQ_LOAD: begin
                if      (req[REQ_DISP]) gnt[REQ_DISP] = 1'b1;
                else if (req[REQ_CORE]) gnt[REQ_CORE] = 1'b1;
                else if (req[REQ_LOAD]) gnt[REQ_LOAD] = 1'b1;
            end
            default: begin
                // DISP (and the unused encoding) hand first priority to CORE
                if      (req[REQ_CORE]) gnt[REQ_CORE] = 1'b1;
                else if (req[REQ_LOAD]) gnt[REQ_LOAD] = 1'b1;
                else if (req[REQ_DISP]) gnt[REQ_DISP] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port BRAM among core, image loader and display reader.
// Latency: grant and memory drive combinational; read data valid 1 cycle after grant.
// Backpressure: losing requesters hold their request; core sees core_stall.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic              core_stall,
    input  logic              load_req,
    input  logic              load_lock,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    output logic              load_gnt,
    input  logic              disp_req,
    input  logic              disp_urgent,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

    logic [1:0] lw;
    logic [7:0] bc;
    logic       ba;
    logic [2:0] rr_gnt;
    logic [2:0] gnt;
    logic [1:0] win_id;
    logic       burst_hold;

    rr_pick3 u_rr (
        .req ({disp_req, load_req, core_req}),
        .lw  (lw),
        .gnt (rr_gnt)
    );

    // A locked burst keeps the loader until the beat cap is reached
    assign burst_hold = ba & load_req & load_lock & (bc < BURST_CAP);

    // Winner selection: urgent display, then locked burst, then round-robin
    always_comb begin
        gnt    = rr_gnt;
        win_id = REQ_DISP;
        if (disp_urgent & disp_req) begin
            gnt = 3'b000;
            gnt[REQ_DISP] = 1'b1;
        end else if (burst_hold) begin
            gnt = 3'b000;
            gnt[REQ_LOAD] = 1'b1;
        end
        if (gnt[REQ_CORE])      win_id = REQ_CORE;
        else if (gnt[REQ_LOAD]) win_id = REQ_LOAD;
    end

    assign core_gnt   = gnt[REQ_CORE];
    assign load_gnt   = gnt[REQ_LOAD];
    assign disp_gnt   = gnt[REQ_DISP];
    assign core_stall = core_req & ~core_gnt;
    assign rdata      = mem_rdata;

    // Steer the winner's address/data onto the memory port; idle drives zeros
    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (load_gnt) begin
            mem_we    = 1'b1;
            mem_addr  = load_addr;
            mem_wdata = load_wdata;
        end else if (disp_gnt) begin
            mem_addr  = disp_addr;
        end
    end

    // Arbitration history: last winner pointer and loader burst tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lw <= REQ_DISP;
            ba <= 1'b0;
            bc <= 8'd0;
        end else begin
            if (|gnt) lw <= win_id;
            if (load_gnt & load_lock) begin
                ba <= 1'b1;
                // A capped loader that wins again by round-robin starts a new burst
                bc <= (bc >= BURST_CAP) ? 8'd1 : bc + 8'd1;
            end else begin
                ba <= 1'b0;
                bc <= 8'd0;
            end
        end
    end

    // Read-return strobes, aligned with the BRAM's one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rvalid <= 1'b0;
            disp_rvalid <= 1'b0;
        end else begin
            core_rvalid <= core_gnt & ~core_we;
            disp_rvalid <= disp_gnt;
        end
    end

endmodule
